// File: rtl/ccc_seq_pkg.sv
// ccc_seq_pkg: shared types and defaults for the CCC lock/reset sequencer.
//   seq_state_e              sequencer state encoding
//   LockStableCyclesDefault  default lock qualification length in GL0 cycles
//   RstHoldCyclesDefault     default reset hold length after qualification
//   max_u()                  larger of two unsigned values, used to size the counter
package ccc_seq_pkg;

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StHold     = 2'd1,
    StRun      = 2'd2
  } seq_state_e;

  localparam int unsigned LockStableCyclesDefault = 1024;
  localparam int unsigned RstHoldCyclesDefault    = 16;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk  destination clock
//   rst  synchronous active-high reset, clears both flops to 0
//   d    asynchronous input
//   q    synchronized output (two clk edges of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ccc_lock_rst_seq.sv
// ccc_lock_rst_seq: holds the fabric in reset until the CCC PLL lock has been
// stable for LOCK_STABLE_CYCLES cycles, then for RST_HOLD_CYCLES more, then
// releases it. Any loss of lock returns to qualification.
// Ports:
//   GL0          fabric clock (only clock)
//   RESET        synchronous active-high reset
//   LOCK         PLL lock, asynchronous to GL0
//   FAB_RESET_N  active-low fabric reset, high only in RUN
//   READY        high only in RUN
//   LOCK_LOST    one-cycle pulse when lock drops while in RUN
//   LOSS_COUNT   saturating lock-loss count (only with CCC_LOCK_LOSS_CNT_EN)
// Configuration macro: CCC_LOCK_LOSS_CNT_EN enables LOSS_COUNT.
module ccc_lock_rst_seq
  import ccc_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = LockStableCyclesDefault,
  parameter int unsigned RST_HOLD_CYCLES    = RstHoldCyclesDefault
) (
  input  logic       GL0,
  input  logic       RESET,
  input  logic       LOCK,
  output logic       FAB_RESET_N,
  output logic       READY,
  output logic       LOCK_LOST
`ifdef CCC_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] LOSS_COUNT
`endif
);

  localparam int unsigned MaxCycles = max_u(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES);
  // Wide enough for MaxCycles-1; at least one bit.
  localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] LockLast = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(RST_HOLD_CYCLES - 1);

  logic lock_s;

  sync_2ff u_sync_lock (
    .clk (GL0),
    .rst (RESET),
    .d   (LOCK),
    .q   (lock_s)
  );

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lock_lost_q, lock_lost_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_lost_d = 1'b0;
    unique case (state_q)
      StWaitLock: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == LockLast) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d     = StWaitLock;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge GL0) begin
    if (RESET) begin
      state_q     <= StWaitLock;
      cnt_q       <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // Decoded straight from the state register so release and the loss pulse line up.
  assign READY       = (state_q == StRun);
  assign FAB_RESET_N = (state_q == StRun);
  assign LOCK_LOST   = lock_lost_q;

`ifdef CCC_LOCK_LOSS_CNT_EN
  logic [7:0] loss_count_q;

  // Updates on the same edge that raises LOCK_LOST, so the count tracks the pulse.
  always_ff @(posedge GL0) begin
    if (RESET) begin
      loss_count_q <= 8'd0;
    end else if (lock_lost_d && (loss_count_q != 8'hFF)) begin
      loss_count_q <= loss_count_q + 8'd1;
    end
  end

  assign LOSS_COUNT = loss_count_q;
`endif

endmodule
